// File: rtl/tdr_capture_bank_pkg.sv
// Shared types and helpers for the multi-channel time-domain capture bank.
package tdr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    READOUT = 2'd2
  } tdr_state_e;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 200;

  // Index width that never collapses to zero bits for a single channel.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdr_capture_bank_if.sv
// Readout port of the capture bank: one beat per channel, valid/ready handshake.
interface tdr_capture_bank_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 8
);
  logic             rd_valid;
  logic             rd_ready;
  logic [CH_W-1:0]  rd_ch;
  logic [CNT_W-1:0] rd_time;
  logic             rd_hit;

  modport master (output rd_valid, rd_ch, rd_time, rd_hit, input rd_ready);
  modport slave  (input rd_valid, rd_ch, rd_time, rd_hit, output rd_ready);
endinterface

// File: rtl/tdr_capture_bank_chan.sv
// One event channel: synchroniser, rising-edge detect, carry flag and timestamp.
// The edge history runs in every state so a level already high at arm time
// never looks like a fresh event.
module tdr_chan #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ev,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] count,
  output logic             carry,
  output logic [CNT_W-1:0] ts,
  output logic             cap
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   carry_q, carry_d;
  logic [CNT_W-1:0]       ts_q, ts_d;
  logic                   rise;

  assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign cap   = enable & rise & ~carry_q;
  assign carry = carry_q;
  assign ts    = ts_q;

  // Next-state: shift the synchroniser, latch the first edge of the window.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], ev};
    prev_d  = sync_q[SYNC_STAGES-1];
    carry_d = carry_q;
    ts_d    = ts_q;
    if (clear) begin
      carry_d = 1'b0;
      ts_d    = '0;
    end else if (cap) begin
      carry_d = 1'b1;
      ts_d    = count;
    end
  end

  // Channel registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      carry_q <= 1'b0;
      ts_q    <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      carry_q <= carry_d;
      ts_q    <= ts_d;
    end
  end

endmodule

// File: rtl/tdr_capture_bank.sv
// Multi-channel capture bank: FSM, shared arm-relative counter, readout mux.
// Optional abort path: define TDR_TIMEOUT_EN to end the window after TIMEOUT
// counts in ARMED even if some channels never fired.
//
// state   | meaning
// IDLE    | waiting for arm; previous window's carry/timestamps held
// ARMED   | counter running, channels capture their first rising edge
// READOUT | one beat per channel drained over rd, then back to IDLE
module tdr_capture_bank
  import tdr_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arm,
  input  logic [N_CH-1:0] ev,
  output logic [N_CH-1:0] carry,
  output logic [N_CH-1:0] carry_b,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  tdr_capture_bank_if.master rd
);

  localparam int              CH_W    = clog2_min1(N_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  tdr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  rd_ch_q, rd_ch_d;
  logic             rd_valid_q, rd_valid_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [N_CH-1:0]  cap;
  logic [CNT_W-1:0] ts [N_CH];
  logic             ch_clear, ch_enable, all_set;

  assign ch_clear  = (state_q == IDLE) && arm;
  assign ch_enable = (state_q == ARMED);
  assign all_set   = &(carry | cap);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    tdr_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .ev     (ev[i]),
      .clear  (ch_clear),
      .enable (ch_enable),
      .count  (cnt_q),
      .carry  (carry[i]),
      .ts     (ts[i]),
      .cap    (cap[i])
    );
  end

`ifdef TDR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT == 0);
`endif

  // FSM next-state, counter and readout index.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_ch_d    = rd_ch_q;
    rd_valid_d = rd_valid_q;
    timeout_d  = timeout_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d   = ARMED;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      ARMED: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (all_set) begin
          state_d    = READOUT;
          rd_valid_d = 1'b1;
          rd_ch_d    = '0;
        end
`ifdef TDR_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d    = READOUT;
          rd_valid_d = 1'b1;
          rd_ch_d    = '0;
          timeout_d  = 1'b1;
        end
`endif
      end
      READOUT: begin
        if (rd.rd_ready) begin
          if (rd_ch_q == LAST_CH) begin
            state_d    = IDLE;
            rd_valid_d = 1'b0;
            rd_ch_d    = '0;
            done_d     = 1'b1;
          end else begin
            rd_ch_d = rd_ch_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_ch_q    <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_ch_q    <= rd_ch_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  // Timestamps and carry only move in ARMED, so the mux is stable during readout.
  assign carry_b     = ~carry;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_ch    = rd_ch_q;
  assign rd.rd_time  = ts[rd_ch_q];
  assign rd.rd_hit   = carry[rd_ch_q];

endmodule

// File: tb/tb_tdr_capture_bank.sv
// Scoreboard bench for tdr_capture_bank (N_CH=4, CNT_W=8, SYNC_STAGES=2, TIMEOUT=50).
module tb_tdr_capture_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0;
  logic       rd_ready = 1'b1;
  logic [3:0] ev = 4'h0;
  logic [3:0] carry, carry_b;
  logic       busy, done, timeout;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {int ch; int tm; int hit;} beat_t;
  beat_t sb[$];

  tdr_capture_bank_if #(.CH_W(2), .CNT_W(8)) rd_if ();
  assign rd_if.rd_ready = rd_ready;

  tdr_capture_bank #(
    .N_CH(4), .CNT_W(8), .SYNC_STAGES(2), .TIMEOUT(50)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .ev(ev),
    .carry(carry), .carry_b(carry_b), .busy(busy), .done(done),
    .timeout(timeout), .rd(rd_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto_cyc(input int n);
    while (cyc < n) step();
  endtask

  task automatic push(input int ch, input int tm, input int hit);
    beat_t b;
    b.ch = ch; b.tm = tm; b.hit = hit;
    sb.push_back(b);
  endtask

  task automatic start_window();
    arm = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      step();
      k++;
    end
    check_eq("done_seen", done, 1);
  endtask

  // Readout monitor: every accepted beat is compared with the scoreboard head.
  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      if (done) done_cnt++;
      if (rd_if.rd_valid && rd_ready) begin
        if (sb.size() == 0) begin
          check_eq("beat_extra", 1, 0);
        end else begin
          b = sb.pop_front();
          check_eq("beat_ch",   rd_if.rd_ch,   b.ch);
          check_eq("beat_time", rd_if.rd_time, b.tm);
          check_eq("beat_hit",  rd_if.rd_hit,  b.hit);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with events toggling.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      ev = ev ^ 4'b0101;
    end
    check_eq("rst_carry",   carry, 4'h0);
    check_eq("rst_carry_b", carry_b, 4'hf);
    check_eq("rst_busy",    busy, 0);
    check_eq("rst_valid",   rd_if.rd_valid, 0);
    check_eq("rst_done",    done, 0);
    check_eq("rst_timeout", timeout, 0);
    ev = 4'h0;
    rst = 1'b0;
    repeat (4) step();

    // Staggered events at counter 10,20,30,40 -> timestamps +2.
    rd_ready = 1'b1;
    start_window();
    check_eq("arm_busy", busy, 1);
    for (int ch = 0; ch < 4; ch++) begin
      goto_cyc(10 * (ch + 1));
      ev[ch] = 1'b1;
      push(ch, 10 * (ch + 1) + 2, 1);
      goto_cyc(10 * (ch + 1) + 2);
      check_eq("lat_early", carry[ch], 0);
      step();
      check_eq("lat_cap", carry[ch], 1);
    end
    check_eq("stag_ro", rd_if.rd_valid, 1);
    wait_done(20);
    step();
    check_eq("stag_done_once", done, 0);
    check_eq("stag_done_cnt", done_cnt, 1);
    check_eq("stag_sb_empty", sb.size(), 0);
    ev = 4'h0;
    repeat (4) step();

    // Simultaneous rises, then backpressure.
    rd_ready = 1'b0;
    start_window();
    goto_cyc(5);
    ev = 4'hf;
    for (int i = 0; i < 4; i++) push(i, 7, 1);
    goto_cyc(7);
    check_eq("sim_pre", carry, 4'h0);
    step();
    check_eq("sim_carry",   carry, 4'hf);
    check_eq("sim_carry_b", carry_b, 4'h0);
    check_eq("sim_ro",      rd_if.rd_valid, 1);
    ev = 4'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_valid", rd_if.rd_valid, 1);
      check_eq("bp_ch",    rd_if.rd_ch, 0);
      check_eq("bp_time",  rd_if.rd_time, 7);
    end
    rd_ready = 1'b1;
    repeat (4) step();
    check_eq("bp_done",  done, 1);
    check_eq("bp_valid_low", rd_if.rd_valid, 0);
    check_eq("bp_sb_empty", sb.size(), 0);

    // Arm in the done cycle starts the next window.
    arm = 1'b1;
    step();
    arm = 1'b0;
    cyc = 0;
    check_eq("arm_in_done", busy, 1);
    check_eq("done_cnt2", done_cnt, 2);

    // Ignore rules: second ev[1] pulse and a mid-window arm have no effect.
    push(0, 22, 1);
    push(1, 5, 1);
    push(2, 22, 1);
    push(3, 22, 1);
    goto_cyc(3);  ev[1] = 1'b1;
    goto_cyc(8);  ev[1] = 1'b0;
    goto_cyc(10); ev[1] = 1'b1;
    goto_cyc(12); arm = 1'b1;
    step();       arm = 1'b0;
    goto_cyc(20); ev = 4'b1101;
    goto_cyc(23);
    check_eq("ign_ro", rd_if.rd_valid, 1);
    wait_done(20);
    step();
    check_eq("held_idle", carry, 4'hf);
    check_eq("done_cnt3", done_cnt, 3);
    ev = 4'h0;
    repeat (4) step();
    ev = 4'hf;
    repeat (4) step();
    check_eq("idle_ign_carry", carry, 4'hf);
    check_eq("idle_ign_busy", busy, 0);
    ev = 4'h0;
    repeat (4) step();

`ifdef TDR_TIMEOUT_EN
    // Timeout: only ev[0] fires, abort at counter 49.
    start_window();
    push(0, 7, 1);
    push(1, 0, 0);
    push(2, 0, 0);
    push(3, 0, 0);
    goto_cyc(5);
    ev[0] = 1'b1;
    goto_cyc(49);
    check_eq("to_pre_valid", rd_if.rd_valid, 0);
    check_eq("to_pre_flag", timeout, 0);
    step();
    check_eq("to_valid", rd_if.rd_valid, 1);
    check_eq("to_flag", timeout, 1);
    wait_done(20);
    check_eq("to_held", timeout, 1);
    arm = 1'b1;
    step();
    arm = 1'b0;
    cyc = 0;
    check_eq("to_clear", timeout, 0);
    for (int i = 0; i < 4; i++) push(i, 0, 0);
    ev = 4'h0;
    goto_cyc(50);
    check_eq("to_again", timeout, 1);
    wait_done(20);
    repeat (2) step();
`else
    check_eq("to_off", timeout, 0);
`endif

    // Reset asserted mid-readout takes effect immediately.
    rd_ready = 1'b0;
    start_window();
    goto_cyc(2);
    ev = 4'hf;
    goto_cyc(5);
    check_eq("mr_ro", rd_if.rd_valid, 1);
    step();
    #3;
    rst = 1'b1;
    #1;
    check_eq("mr_carry",   carry, 4'h0);
    check_eq("mr_carry_b", carry_b, 4'hf);
    check_eq("mr_busy",    busy, 0);
    check_eq("mr_valid",   rd_if.rd_valid, 0);
    check_eq("mr_ch",      rd_if.rd_ch, 0);
    check_eq("mr_done",    done, 0);
    ev = 4'h0;
    #10;
    rst = 1'b0;
    repeat (3) step();
    check_eq("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tdr_capture_bank.md
Name: tdr_capture_bank

Overview:
- Multi-channel, parametrised successor to the single-shot time-domain register latch.
- N_CH event inputs are synchronised into clk and rising-edge detected.
- Each channel latches a carry/carry_b flag plus a coarse timestamp from a shared arm-relative counter.
- Captured results are drained through a valid/ready readout port; the block sits between asynchronous event sources and the TDR readout/processing logic.

Parameters:
- N_CH, 4, number of event channels (>=1)
- CNT_W, 8, coarse timestamp counter width
- SYNC_STAGES, 2, synchroniser flops per channel (>=2)
- TIMEOUT, 200, abort count in ARMED; used only with TDR_TIMEOUT_EN; must be <= 2^CNT_W-1

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- arm  in  1  start a capture window (sampled in IDLE only)
- ev  in  N_CH  asynchronous event inputs
- carry  out  N_CH  per-channel captured flag
- carry_b  out  N_CH  bitwise inverse of carry
- busy  out  1  high when state != IDLE
- done  out  1  one-cycle pulse on return to IDLE after readout
- rd_valid  out  1  readout beat valid
- rd_ready  in  1  readout sink ready
- rd_ch  out  max(1,$clog2(N_CH))  channel index of current beat
- rd_time  out  CNT_W  timestamp of rd_ch
- rd_hit  out  1  carry[rd_ch]
- timeout  out  1  window aborted (constant 0 without the macro)

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-window or mid-readout):
  - State IDLE; all sync flops, edge history, counter, timestamps, rd_ch = 0.
  - carry = 0, carry_b = all 1, busy/done/rd_valid/timeout = 0.
- Sync/edge detect:
  - ev passes through SYNC_STAGES flops; rise = synced & ~prev.
  - Edge history updates in every state.
  - Latency from ev change to carry high: SYNC_STAGES+1 edges.
- States (from tdr_state_e): IDLE, ARMED, READOUT.
- IDLE:
  - arm=1 -> ARMED next cycle; counter, carry and timestamps cleared on that edge.
  - Rises in IDLE are ignored; carry and timestamps from the previous window are held.
- ARMED:
  - Counter = 0 in the first ARMED cycle; +1 per cycle; saturates at 2^CNT_W-1.
  - rise[i] & ~carry[i] -> carry[i] <= 1, ts[i] <= current counter.
  - Later edges on a captured channel are ignored.
  - Simultaneous rises on several channels all get the same counter value.
  - arm is ignored while in ARMED.
  - When all carry bits are set (including bits set this edge) -> READOUT next cycle.
  - Without timeout, the block stays ARMED indefinitely; captures after saturation record the all-ones value.
- READOUT:
  - rd_valid = 1; rd_ch starts at 0.
  - rd_time = ts[rd_ch]; rd_hit = carry[rd_ch].
  - While rd_valid & ~rd_ready, all rd_* outputs are held stable.
  - On rd_valid & rd_ready: rd_ch increments.
  - After channel N_CH-1 is accepted -> IDLE, rd_valid = 0, done = 1 for exactly that first IDLE cycle.
  - An arm in that same cycle is accepted.
  - arm is ignored in READOUT.
- carry and carry_b are registered and change only on capture, arm-clear or reset.

Optional Feature:
- Macro: TDR_TIMEOUT_EN
- Defined:
  - In ARMED, when counter == TIMEOUT-1 and not all channels are captured -> READOUT next cycle.
  - timeout is set on that transition and held until the next accepted arm or reset.
  - Uncaptured channels read rd_hit = 0, rd_time = 0.
  - A capture on the same edge as the timeout condition is still recorded.
- Undefined: timeout is tied to 0, TIMEOUT is unused, and no abort path exists.

Decomposition:
- Package tdr_pkg:
  - tdr_state_e enum {IDLE, ARMED, READOUT}
  - function clog2_min1 for rd_ch width
  - default-width localparams
- Sub-module tdr_chan (one per channel via generate):
  - synchroniser, edge detect, carry flag and ts register
  - inputs: clk, rst, clear, enable, count
- Top level holds the FSM, counter and readout mux.

Test Plan (N_CH=4, CNT_W=8, SYNC_STAGES=2):
- Reset: rst=1 for 3 cycles, ev toggling -> carry=0000, carry_b=1111, busy=0, rd_valid=0; same values asserted immediately when rst rises mid-READOUT.
- Staggered events: arm, then ev[0..3] rise at first sampling edges where counter=10,20,30,40 -> carry bits set 3 edges later; readout beats (ch,time,hit) = (0,12,1),(1,22,1),(2,32,1),(3,42,1); done pulses once.
- Simultaneous: ev=1111 rises together -> all ts equal; READOUT on the cycle after capture.
- Backpressure: rd_ready=0 for 5 cycles -> rd_valid=1, rd_ch=0 and rd_time stable; then rd_ready=1 -> 4 consecutive beats, rd_ch 0..3.
- Ignore rules: second pulse on ev[1] after capture -> ts[1] unchanged; arm pulse during ARMED -> counter not restarted; arm in the done cycle -> busy=1 next cycle.
- TDR_TIMEOUT_EN with TIMEOUT=50: only ev[0] rises -> READOUT when counter=49; timeout=1; rd_hit sequence 1,0,0,0; rd_time for ch1..3 = 0; timeout clears on next arm.
